// File: rtl/matrix_rowcol_summer.sv
// matrix_rowcol_summer: accumulates row/column/total sums of an N x N row-major frame and emits them as a beat stream
module matrix_rowcol_summer #(
  parameter int DATA_W = 8,
  parameter int N = 4,
  parameter int OUT_W = DATA_W + 2 * $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [1:0]           out_kind,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last
);
  localparam int LW = $clog2(N);
  localparam int SW = DATA_W + LW;
  localparam int EW = $clog2(2 * N + 1);
  typedef enum logic {LOAD, EMIT} state_t;
  state_t state, state_nx;
  logic [2*LW-1:0] elem_cnt;
  logic [EW-1:0] emit_cnt;
  logic [SW-1:0] row_acc [N];
  logic [SW-1:0] col_acc [N];
  logic [OUT_W-1:0] total;
  logic accept, beat, frame_end, is_row, is_col;
  assign accept = in_valid & in_ready;
  assign beat = out_valid & out_ready;
  assign frame_end = beat & out_last;
  assign is_row = emit_cnt < EW'(N);
  assign is_col = emit_cnt < EW'(2 * N);
  // state register
  always_ff @(posedge clk)
    if (rst) state <= LOAD;
    else state <= state_nx;
  // next-state: leave LOAD on the last element, leave EMIT on the total beat
  always_comb begin
    state_nx = state;
    if (state == LOAD && accept && elem_cnt == (2*LW)'(N * N - 1)) state_nx = EMIT;
    if (state == EMIT && frame_end) state_nx = LOAD;
  end
  // outputs: emit counter selects the row sums, then column sums, then total
  always_comb begin
    in_ready = state == LOAD;
    out_valid = state == EMIT;
    out_last = out_valid && emit_cnt == EW'(2 * N);
    out_kind = !out_valid ? 2'd0 : is_row ? 2'd0 : is_col ? 2'd1 : 2'd2;
    out_idx = out_valid && is_col ? emit_cnt[LW-1:0] : '0;
    out_data = !out_valid ? '0 :
               is_row ? OUT_W'(row_acc[emit_cnt[LW-1:0]]) :
               is_col ? OUT_W'(col_acc[emit_cnt[LW-1:0]]) : total;
  end
  // datapath: accumulate on accepts in LOAD, step emit counter on beats, clear after the total beat
  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      elem_cnt <= '0;
      emit_cnt <= '0;
      total <= '0;
      for (int i = 0; i < N; i++) begin
        row_acc[i] <= '0;
        col_acc[i] <= '0;
      end
    end else if (accept) begin
      row_acc[elem_cnt[2*LW-1:LW]] <= row_acc[elem_cnt[2*LW-1:LW]] + SW'(in_data);
      col_acc[elem_cnt[LW-1:0]] <= col_acc[elem_cnt[LW-1:0]] + SW'(in_data);
      total <= total + OUT_W'(in_data);
      elem_cnt <= elem_cnt + 1'b1;
    end else if (beat) begin
      emit_cnt <= emit_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_matrix_rowcol_summer.sv
// tb_matrix_rowcol_summer: directed vectors for the 4x4 row/column summer
module tb_matrix_rowcol_summer;
  typedef int arr4_t[4];
  typedef int arr16_t[16];
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic [7:0] in_data = 0;
  logic [11:0] out_data;
  logic [1:0] out_kind;
  logic [1:0] out_idx;
  int pass_cnt = 0, total_cnt = 0;
  int stall_at = -1, stall_len = 0, busy_cnt;
  arr16_t seq, v;
  arr4_t r, c;

  matrix_rowcol_summer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kind(out_kind), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask

  task automatic feed(input arr16_t vals, input int n, input int gap, input bit hold);
    for (int k = 0; k < n; k++) begin
      check("in_ready_load", int'(in_ready), 1);
      in_valid = 1;
      in_data = 8'(vals[k]);
      @(negedge clk);
      if (gap > 0 && k < n - 1) begin
        in_valid = 0;
        for (int g = 0; g < gap; g++) begin
          check("in_ready_gap", int'(in_ready), 1);
          @(negedge clk);
        end
      end
    end
    in_valid = hold;
  endtask

  task automatic drain(input arr4_t rows, input arr4_t cols, input int tot, input bit first_now);
    busy_cnt = 0;
    for (int b = 0; b < 9; b++) begin
      int t = 0;
      int exp_data = b < 4 ? rows[b] : b < 8 ? cols[b-4] : tot;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (b == 0 && first_now) check("first_beat_latency", t, 0);
      check("out_valid", int'(out_valid), 1);
      if (b == stall_at) begin
        out_ready = 0;
        for (int s = 0; s < stall_len; s++) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'(out_data), exp_data);
          check("stall_idx", int'(out_idx), b % 4);
          busy_cnt += in_ready ? 0 : 1;
          @(negedge clk);
        end
        out_ready = 1;
      end
      check("data", int'(out_data), exp_data);
      check("kind", int'(out_kind), b < 4 ? 0 : b < 8 ? 1 : 2);
      check("idx", int'(out_idx), b < 8 ? b % 4 : 0);
      check("last", int'(out_last), b == 8 ? 1 : 0);
      busy_cnt += in_ready ? 0 : 1;
      @(negedge clk);
    end
    check("post_in_ready", int'(in_ready), 1);
    check("post_out_valid", int'(out_valid), 0);
    check("post_out_last", int'(out_last), 0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) seq[k] = k + 1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_kind", int'(out_kind), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    out_ready = 1;
    rst = 0;
    @(negedge clk);
    r = '{10, 26, 42, 58};
    c = '{28, 32, 36, 40};
    feed(seq, 16, 0, 0);
    drain(r, c, 136, 1);
    check("busy_cycles", busy_cnt, 9);
    for (int k = 0; k < 16; k++) v[k] = 255;
    feed(v, 16, 0, 0);
    drain('{1020, 1020, 1020, 1020}, '{1020, 1020, 1020, 1020}, 4080, 1);
    stall_at = 2;
    stall_len = 3;
    feed(seq, 16, 0, 0);
    drain(r, c, 136, 1);
    stall_at = -1;
    stall_len = 0;
    feed(seq, 16, 2, 0);
    drain(r, c, 136, 1);
    for (int k = 0; k < 16; k++) v[k] = 9;
    feed(v, 7, 0, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 16; k++) v[k] = 2;
    feed(v, 16, 0, 0);
    drain('{8, 8, 8, 8}, '{8, 8, 8, 8}, 32, 1);
    for (int k = 0; k < 16; k++) v[k] = 3;
    in_data = 3;
    feed(seq, 16, 0, 1);
    in_data = 3;
    drain(r, c, 136, 1);
    feed(v, 16, 0, 0);
    drain('{12, 12, 12, 12}, '{12, 12, 12, 12}, 48, 1);
    for (int k = 0; k < 16; k++) v[k] = 0;
    feed(v, 16, 0, 0);
    drain('{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/matrix_rowcol_summer.md
Name: matrix_rowcol_summer

Overview:
- Downstream consumer of the 4x4 matrix loader's element stream. Accepts one N x N frame of unsigned elements in row-major order: element k sits at row = k / N, col = k mod N.
- Accumulates per-row and per-column sums while the frame streams in.
- After the frame completes, emits the N row sums, then the N column sums, then the frame total, on a valid/ready output port.
- Feeds the statistics/checksum logic that follows the matrix stage.

Parameters:
- DATA_W, 8, element width in bits.
- N, 4, matrix dimension. Must be a power of two, 2..16.
- OUT_W, DATA_W + 2*$clog2(N), output width. Row, column and total sums cannot overflow at this width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept an element.
- in_data  input  DATA_W  unsigned matrix element, row-major order.
- out_valid  output  1  out_data/out_kind/out_idx/out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  OUT_W  sum value, zero-extended.
- out_kind  output  2  0 = row sum, 1 = column sum, 2 = total; 3 is never driven.
- out_idx  output  $clog2(N)  row/column index; 0 on the total beat.
- out_last  output  1  high on the total beat only.

Behaviour:
- Reset is synchronous and active-high, applied on the clk edge where rst=1, and overrides all other activity.
  - Reset state is LOAD.
  - Element counter, emit counter, all N row accumulators, N column accumulators and the total accumulator are cleared to 0.
  - in_ready=1, out_valid=0, out_data=0, out_kind=0, out_idx=0, out_last=0.
- Two-state FSM: LOAD and EMIT.
- LOAD:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On each accept:
    - row_acc[elem_cnt / N] += in_data.
    - col_acc[elem_cnt mod N] += in_data.
    - total += in_data.
    - elem_cnt increments.
  - No accept means no state change; gaps in in_valid are allowed anywhere.
  - On the accept with elem_cnt = N*N-1, the next state is EMIT, elem_cnt wraps to 0 and emit_cnt = 0.
- EMIT:
  - in_ready=0 in every EMIT cycle; in_valid is ignored.
  - out_valid=1 from the first EMIT cycle. This is one cycle after the last input accept.
  - Beat sequence by emit_cnt, 2N+1 beats:
    - 0..N-1: row sums (kind 0, idx = emit_cnt).
    - N..2N-1: column sums (kind 1, idx = emit_cnt - N).
    - 2N: total (kind 2, idx 0, out_last=1).
  - A beat completes on out_valid & out_ready, and emit_cnt then increments.
  - While out_ready=0, all out_* signals hold stable. Accumulators are frozen during EMIT.
  - On completion of the total beat, the same edge does the following:
    - Clears all accumulators.
    - Drives out_valid=0 and out_last=0.
    - Returns to LOAD; in_ready=1 in the following cycle.
  - Input and output of consecutive frames never overlap.
  - Minimum frame period is N*N + 2N+1 cycles.
- Arithmetic:
  - Unsigned, no saturation needed.
  - Row and column sums need DATA_W + $clog2(N) bits; they are zero-extended to OUT_W.
  - The total fits OUT_W exactly.
- Boundary conditions:
  - A frame of all-zero elements still emits 2N+1 beats of value 0.
  - out_ready held high gives one beat per cycle.
  - out_ready may be asserted before out_valid with no effect.
  - rst asserted mid-frame or mid-emit discards the partial frame. The next accepted element is element 0 of a new frame.

Test Plan:
- Reset, then stream 1..16 back-to-back with out_ready=1 -> beats, one per cycle, first beat one cycle after the 16th accept:
  - rows 10, 26, 42, 58;
  - cols 28, 32, 36, 40;
  - total 136 with out_last=1;
  - in_ready=0 for exactly 9 cycles.
- All elements 255 -> every row and column sum is 1020, total 4080 (12-bit max used); out_kind/out_idx sequence 0/0..0/3, 1/0..1/3, 2/0.
- Stream 1..16 with out_ready low for 3 cycles while the beat with kind 0, idx 2 (value 42) is presented -> out_valid, out_data=42, out_idx=2 held for 4 cycles; no beat lost or duplicated.
- Stream 1..16 with in_valid toggling 1,0,0,1,... -> sums identical to the first scenario; in_ready stays 1 throughout LOAD.
- Accept 7 elements of value 9, pulse rst for 1 cycle, then stream 16 elements of value 2 -> rows 8, cols 8, total 32; no residue from the aborted frame.
- Two frames back-to-back (1..16, then all 3) with in_valid held high -> the second frame's first accept occurs the cycle after the first frame's total beat completes; second frame outputs rows 12, cols 12, total 48.
